// File: rtl/lifo_arbiter.sv
// rtl/lifo_arbiter.sv - two-client push/pop arbiter and sequencer for a shared LIFO stack
// Optional: LIFO_ARB_FIXED_PRIO_EN makes client 0 always win ties (no last-served pointer).
module lifo_arbiter #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] dout,
  output logic          stk_en,
  output logic          stk_rst,
  output logic          stk_rw,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  output logic [CW-1:0] count
);

  typedef enum logic [1:0] {INIT, IDLE, ISSUE, RESP} state_t;

  state_t        state;
  logic          sel;
  logic          sel_rw;
  logic          sel_err;
  logic          pick;
  logic          pick_rw;
  logic [DW-1:0] pick_din;
  logic          illegal;

`ifndef LIFO_ARB_FIXED_PRIO_EN
  logic          last;
`endif

  always_comb begin
`ifdef LIFO_ARB_FIXED_PRIO_EN
    pick = !req0;
`else
    pick = req1 && (!req0 || !last);
`endif
    pick_rw  = pick ? rw1 : rw0;
    pick_din = pick ? din1 : din0;
    illegal  = pick_rw ? (count == '0) : (count == CW'(DEPTH));
  end

  // The stack presents pop data on the edge that ends ISSUE, so it is passed through during RESP.
  assign dout = ((ack0 || ack1) && sel_rw && !sel_err) ? stk_dout : '0;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= INIT;
      count   <= '0;
      sel     <= 1'b0;
      sel_rw  <= 1'b0;
      sel_err <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      stk_en  <= 1'b0;
      stk_rst <= 1'b0;
      stk_rw  <= 1'b0;
      stk_din <= '0;
`ifndef LIFO_ARB_FIXED_PRIO_EN
      last    <= 1'b1;
`endif
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      stk_en  <= 1'b0;
      stk_rst <= 1'b0;
      stk_rw  <= 1'b0;
      stk_din <= '0;
      case (state)
        INIT: begin
          // Outputs are registered: raise the flush pulse once, then leave when it has been seen.
          if (!stk_rst) begin
            stk_en  <= 1'b1;
            stk_rst <= 1'b1;
            count   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (req0 || req1) begin
            sel     <= pick;
            sel_rw  <= pick_rw;
            sel_err <= illegal;
            if (illegal) begin
              state <= RESP;
              ack0  <= !pick;
              ack1  <= pick;
              err0  <= !pick;
              err1  <= pick;
            end else begin
              state   <= ISSUE;
              gnt0    <= !pick;
              gnt1    <= pick;
              stk_en  <= 1'b1;
              stk_rw  <= pick_rw;
              stk_din <= pick_din;
            end
          end
        end
        ISSUE: begin
          state <= RESP;
          count <= sel_rw ? count - CW'(1) : count + CW'(1);
          ack0  <= !sel;
          ack1  <= sel;
        end
        RESP: begin
          state <= IDLE;
`ifndef LIFO_ARB_FIXED_PRIO_EN
          last  <= sel;
`endif
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
// tb/tb_lifo_arbiter.sv - directed self-checking bench for lifo_arbiter with a behavioural stack
module tb_lifo_arbiter;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
  logic [3:0] din0 = '0, din1 = '0;
  logic       gnt0, gnt1, ack0, ack1, err0, err1;
  logic [3:0] dout;
  logic       stk_en, stk_rst, stk_rw;
  logic [3:0] stk_din;
  logic [3:0] stk_dout = '0;
  logic [2:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;

  logic [3:0] smem [4];
  int         sp = 0;

  always #5 Clk = ~Clk;

  lifo_arbiter #(.DW(4), .DEPTH(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .dout(dout), .stk_en(stk_en), .stk_rst(stk_rst), .stk_rw(stk_rw),
    .stk_din(stk_din), .stk_dout(stk_dout), .count(count)
  );

  // Stack model: synchronous flush, registered dataOut on pop.
  always @(posedge Clk) begin
    if (stk_en) begin
      en_cnt <= en_cnt + 1;
      if (stk_rst) begin
        sp <= 0;
      end else if (!stk_rw) begin
        smem[sp & 3] <= stk_din;
        sp <= sp + 1;
      end else begin
        stk_dout <= smem[(sp - 1) & 3];
        sp <= sp - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset(input string tag);
    Rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check({tag, ".rst_outs"}, 32'({gnt0, gnt1, ack0, ack1, err0, err1, stk_en, stk_rst, stk_rw}), 32'd0);
    check({tag, ".rst_cnt"}, 32'(count), 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    check({tag, ".flush"}, 32'({stk_en, stk_rst}), 32'b11);
    @(negedge Clk);
    check({tag, ".post_flush"}, 32'({stk_en, stk_rst, stk_rw}), 32'd0);
    check({tag, ".cnt0"}, 32'(count), 32'd0);
  endtask

  task automatic do_op(input string tag, input int c, input logic rw, input logic [3:0] d,
                       input logic exp_err, input logic [3:0] exp_dout);
    int n = 0;
    int en0 = en_cnt;
    logic saw_gnt = 1'b0, got_ack = 1'b0, got_err = 1'b0;
    logic [3:0] got_dout = '0;
    if (c == 0) begin req0 = 1'b1; rw0 = rw; din0 = d; end
    else        begin req1 = 1'b1; rw1 = rw; din1 = d; end
    while (!got_ack && n < 20) begin
      @(negedge Clk);
      n++;
      if ((c == 0) ? gnt0 : gnt1) saw_gnt = 1'b1;
      if ((c == 0) ? ack0 : ack1) begin
        got_ack  = 1'b1;
        got_err  = (c == 0) ? err0 : err1;
        got_dout = dout;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check({tag, ".ack"}, 32'(got_ack), 32'd1);
    check({tag, ".lat"}, 32'(n), exp_err ? 32'd1 : 32'd2);
    check({tag, ".err"}, 32'(got_err), 32'(exp_err));
    check({tag, ".dout"}, 32'(got_dout), 32'(exp_dout));
    check({tag, ".gnt"}, 32'(saw_gnt), 32'(!exp_err));
    check({tag, ".stk_en"}, 32'(en_cnt - en0), exp_err ? 32'd0 : 32'd1);
    @(negedge Clk);
  endtask

  initial begin
    logic [3:0] pushes [4];
    logic [3:0] pops_exp [4];
    logic       exp_g [4];
    int         gq [$];
    logic       e13;

    pushes = '{4'h3, 4'h5, 4'h9, 4'hC};
    apply_reset("init");

    foreach (pushes[i]) do_op($sformatf("push%0d", i), 0, 1'b0, pushes[i], 1'b0, 4'h0);
    check("full.cnt", 32'(count), 32'd4);
    do_op("push_full", 0, 1'b0, 4'h1, 1'b1, 4'h0);
    check("full.cnt_hold", 32'(count), 32'd4);

    for (int i = 3; i >= 0; i--) do_op($sformatf("pop%0d", i), 1, 1'b1, 4'h0, 1'b0, pushes[i]);
    do_op("pop_empty", 1, 1'b1, 4'h0, 1'b1, 4'h0);
    check("empty.cnt", 32'(count), 32'd0);

    // Both clients hold push requests continuously.
`ifdef LIFO_ARB_FIXED_PRIO_EN
    exp_g    = '{1'b0, 1'b0, 1'b0, 1'b0};
    pops_exp = '{4'hA, 4'hA, 4'hA, 4'hA};
`else
    exp_g    = '{1'b0, 1'b1, 1'b0, 1'b1};
    pops_exp = '{4'hB, 4'hA, 4'hB, 4'hA};
`endif
    req0 = 1'b1; rw0 = 1'b0; din0 = 4'hA;
    req1 = 1'b1; rw1 = 1'b0; din1 = 4'hB;
    e13 = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge Clk);
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
      if (i == 13) e13 = ack0 && err0;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge Clk);
    check("rr.ngnt", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr.gnt%0d", i), (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF, 32'(exp_g[i]));
    check("rr.err0", 32'(e13), 32'd1);
    check("rr.cnt", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) do_op($sformatf("rr_pop%0d", i), 1, 1'b1, 4'h0, 1'b0, pops_exp[i]);

    apply_reset("re");
    do_op("empty_pop0", 0, 1'b1, 4'h0, 1'b1, 4'h0);
    do_op("empty_pop1", 1, 1'b1, 4'h0, 1'b1, 4'h0);
    check("empty2.cnt", 32'(count), 32'd0);

    // Reset while the push is in ISSUE.
    req0 = 1'b1; rw0 = 1'b0; din0 = 4'h7;
    @(negedge Clk);
    check("abort.gnt", 32'(gnt0), 32'd1);
    Rst = 1'b1;
    req0 = 1'b0;
    #1;
    check("abort.async", 32'({gnt0, ack0, stk_en}), 32'd0);
    apply_reset("abort");
    do_op("abort_pop", 0, 1'b1, 4'h0, 1'b1, 4'h0);
    check("abort.cnt", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lifo_arbiter.md
# lifo_arbiter

Two-requester arbiter and sequencer for the shared 4-entry LIFO stack buffer. Accepts push/pop requests from two independent clients, serialises them onto the stack's single EN/RW/dataIn/dataOut port, and tracks occupancy so illegal operations never reach the stack. It also flushes the stack after reset. It sits between the client blocks and the stack instance, and drives every stack control input.

## Interface
- DW, 4, data width of stack entries
- DEPTH, 4, stack capacity; the arbiter's occupancy count saturates here
- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request from client 0 / 1; held high until ack
- rw0 / rw1  in  1  0 = push, 1 = pop; stable while req high
- din0 / din1  in  DW  push data; stable while req high
- gnt0 / gnt1  out  1  one-cycle pulse: this client's operation is being issued
- ack0 / ack1  out  1  one-cycle pulse: operation complete
- err0 / err1  out  1  valid with ack: operation rejected (push when full, pop when empty)
- dout  out  DW  pop data; valid with ack0/ack1
- stk_en  out  1  to stack EN
- stk_rst  out  1  to stack Rst (synchronous at the stack)
- stk_rw  out  1  to stack RW
- stk_din  out  DW  to stack dataIn
- stk_dout  in  DW  from stack dataOut
- count  out  clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- States: INIT, IDLE, ISSUE, RESP.
- INIT: drives stk_en=1 and stk_rst=1 for exactly one cycle, which flushes the stack. Sets count=0. Next state is IDLE.
- IDLE: if no req is high, remain in IDLE. Otherwise select one client:
  - only one req high: select that client;
  - both high: round-robin, picking the client not served last.
- After selection in IDLE:
  - Illegal operation (push with count==DEPTH, or pop with count==0): go to RESP with err set. No stack access, no gnt.
  - Legal operation: go to ISSUE.
- ISSUE: for one cycle, drive stk_en=1, stk_rw=rw of the selected client, stk_din=din of the selected client, and gnt of the selected client=1. On the exit edge, count increments on push or decrements on pop.
- RESP: ack of the selected client=1 and err of the selected client as decided in IDLE.
  - Pop: dout=stk_dout, captured in this cycle.
  - Push or error: dout=0.
  - The round-robin "last served" pointer updates to this client. Next state is IDLE.
- The served client must drop or change its req on the cycle after ack. A req still high in IDLE is treated as a new request.
- stk_en=0 in every state except INIT and ISSUE. stk_rst=1 only in INIT.
- A client that is not selected sees no gnt/ack and keeps waiting. Requests are never dropped.
- count never wraps: the error check in IDLE guarantees it stays within 0..DEPTH.

## Timing
- Reset values (while Rst high): state=INIT, count=0, last-served pointer=client 1 (so client 0 wins the first tie). All outputs 0, including stk_en and stk_rst.
- Cycle 0 after Rst deasserts: INIT. The stack flush occurs on the following edge.
- Legal operation: req sampled in IDLE at edge N; gnt high during cycle N+1 (ISSUE); ack high during cycle N+2 (RESP), with dout valid. Latency is 2 cycles and one operation completes every 3 cycles.
- Rejected operation: ack/err high during cycle N+1. Latency is 1 cycle.
- Rst asserted mid-operation: the operation aborts immediately and no ack is produced. On release the block re-runs INIT, flushing the stack and resetting count to 0.
- Simultaneous push from one client and pop from the other: served in round-robin order. Pop data reflects the stack contents after the earlier operation.

## Configuration
- LIFO_ARB_FIXED_PRIO_EN defined: client 0 always wins when both req are high. The last-served pointer is not implemented.
- Not defined: round-robin as described in Operation.

## Test plan
- Reset, then idle: stk_rst=stk_en=1 for exactly one cycle after release, then all stack controls 0 and count=0.
- Client 0 pushes 0x3, 0x5, 0x9, 0xC, then a fifth push of 0x1: the four pushes ack with err=0 and count reaches 4; the fifth acks with err0=1 one cycle after sampling, with no stk_en pulse.
- Client 1 pops 5 times after the previous scenario: dout sequence 0xC, 0x9, 0x5, 0x3 with err1=0; the fifth pop gives err1=1, dout=0, count=0.
- Both clients hold req continuously (client 0 pushing 0xA, client 1 pushing 0xB): grants alternate 0,1,0,1 in round-robin mode; with LIFO_ARB_FIXED_PRIO_EN, client 0 is granted until count=4 and then err0 is returned.
- Pop on an empty stack from either client immediately after reset: err set, no stack access, count stays 0.
- Rst asserted during ISSUE of a push: no ack; after release, INIT re-flushes, count=0, and the first pop returns err.
